gray_counter: RTL and testbench

// - Free-running WIDTH-bit Gray-code counter; exactly one output bit changes per clock.
// - Leaf block for sequencing and pointer generation, and for safe multi-bit values crossing clock domains.
// - Registered output; no enable and no load.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_bin2gray.sv | 14 +
 rtl/gray_counter.sv | 61 ++++++
 tb/tb_gray_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the gray_counter slice.
package gray_pkg;

  localparam int unsigned GRAY_DEFAULT_WIDTH = 2;
  localparam int unsigned GRAY_MAX_WIDTH     = 16;

  // Binary to reflected Gray code.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray code back to binary: running XOR from the MSB downward.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Combinational WIDTH-bit binary to Gray converter.
module gray_bin2gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Widen to the package helper's width and trim back.
  assign gray = WIDTH'(bin2gray(16'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Free-running WIDTH-bit Gray-code counter with registered output.
// Optional simulation-only single-bit-change checker enabled by GRAY_CHECK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next_c;
  logic [WIDTH-1:0] gray_next_c;

  // Next binary count, wrapping naturally at 2^WIDTH.
  assign bin_next_c = bin + WIDTH'(1);

  gray_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_next_c),
    .gray (gray_next_c)
  );

  // Binary and Gray registers advance together so gray_out == gray(bin).
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin      <= '0;
      gray_out <= '0;
    end else begin
      bin      <= bin_next_c;
      gray_out <= gray_next_c;
    end
  end

`ifdef GRAY_CHECK_EN
`ifndef SYNTHESIS
  logic [WIDTH-1:0] chk_prev;
  logic             chk_valid;

  // Flag any run-cycle step where the output changed by other than one bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_valid <= 1'b0;
      chk_prev  <= '0;
    end else begin
      if (chk_valid && ($countones(gray_out ^ chk_prev) != 1)) begin
        $error("gray_counter: output %h -> %h is not a single-bit step", chk_prev, gray_out);
      end
      chk_prev  <= gray_out;
      chk_valid <= 1'b1;
    end
  end
`endif
`else
  // Checker not built; function and timing are unaffected.
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH 1, 2, 3 and 4.
module tb_gray_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic [0:0] g1;
  logic [1:0] g2;
  logic [2:0] g3;
  logic [3:0] g4;

  int tests;
  int failed;
  int n;          // edges with rst==1 since the last reset edge
  logic ran;      // last edge was a run edge
  logic [1:0] p2;
  logic [2:0] p3;
  logic [3:0] p4;
  logic [0:0] p1;

  gray_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .gray_out(g1));
  gray_counter #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .gray_out(g2));
  gray_counter #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .gray_out(g3));
  gray_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .gray_out(g4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (n=%0d t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // Reference: k-th count reduced mod 2^w, then Gray-coded arithmetically.
  function automatic logic [15:0] exp_gray(input int w, input int k);
    int m;
    m = k % (1 << w);
    return 16'(m ^ (m / 2));
  endfunction

  // Advance one clock; update the model from the rst value seen at the edge.
  task automatic tick();
    p1 = g1; p2 = g2; p3 = g3; p4 = g4;
    @(posedge clk);
    ran = rst;
    if (!rst) n = 0;
    else      n++;
    #1;
  endtask

  // Compare every instance against the model, plus step properties on run edges.
  task automatic check_all(input string tag);
    check({tag, "_w1"}, 16'(g1), exp_gray(1, n));
    check({tag, "_w2"}, 16'(g2), exp_gray(2, n));
    check({tag, "_w3"}, 16'(g3), exp_gray(3, n));
    check({tag, "_w4"}, 16'(g4), exp_gray(4, n));
    if (ran) begin
      check({tag, "_ham2"}, 16'($countones(g2 ^ p2)), 16'd1);
      check({tag, "_ham3"}, 16'($countones(g3 ^ p3)), 16'd1);
      check({tag, "_ham4"}, 16'($countones(g4 ^ p4)), 16'd1);
      check({tag, "_tog1"}, 16'(g1 ^ p1), 16'd1);
      check({tag, "_g2b4"}, gray2bin(16'(g4)), 16'((gray2bin(16'(p4)) + 16'd1) % 16'd16));
    end
  endtask

  logic [1:0] seq2 [6];
  logic [2:0] seq3 [8];
  logic [3:0] hold4;

  initial begin
    tests  = 0;
    failed = 0;
    n      = 0;
    ran    = 1'b0;
    seq2 = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    seq3 = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    // Reset for one clock, then hold it a couple more.
    rst = 1'b0;
    tick();
    check("reset_w2", 16'(g2), 16'h0);
    check_all("reset");
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all("reset_hold");
    end

    // Release: fixed sequences for WIDTH 2 and 3 straight from reset.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 6) check("seq_w2", 16'(g2), 16'(seq2[i]));
      check("seq_w3", 16'(g3), 16'(seq3[i]));
      check_all("release");
    end

    // Run to WIDTH-2 output 11, then reset for two clocks mid-count.
    while (g2 != 2'b11) tick();
    check("pre_mid_w2", 16'(g2), 16'h3);
    rst = 1'b0;
    tick(); check("mid_rst0_w2", 16'(g2), 16'h0);
    tick(); check("mid_rst1_w2", 16'(g2), 16'h0);
    rst = 1'b1;
    tick(); check("mid_rel_w2", 16'(g2), 16'h1);
    check_all("mid_rel");

    // Reset pulse entirely between edges must not disturb the count.
    tick();
    hold4 = g4;
    #2 rst = 1'b0;
    #2 check("sync_only_w4", 16'(g4), 16'(hold4));
    rst = 1'b1;
    tick();
    check_all("after_pulse");

    // Randomised run with occasional reset; includes a long stretch for WIDTH 4.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      tick();
      check_all("rand");
    end

    // 64 uninterrupted clocks on WIDTH 4.
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      check_all("run64");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
